ecdsa_vector_player: RTL and testbench



---
 rtl/ecdsa_vec_pkg.sv | 46 ++++
 rtl/ecdsa_vec_timeout_ctr.sv | 35 +++
 rtl/ecdsa_vector_player.sv | 168 ++++++++++++++++
 tb/tb_ecdsa_vector_player.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_vec_pkg.sv
// Shared types for the ECDSA vector player.
//   expect_e    : expected verdict encoding carried in each ROM vector
//   ecdsa_vec_t : one complete verification vector as stored in the ROM
//   state_e     : sequencer states
//   grade_f     : compares an engine verdict against the expected verdict
package ecdsa_vec_pkg;

  localparam int VEC_KEY_W  = 256;
  localparam int VEC_HASH_W = 512;

  typedef enum logic [1:0] {
    VALID      = 2'd0,
    INVALID    = 2'd1,
    ACCEPTABLE = 2'd2,
    SKIP       = 2'd3
  } expect_e;

  typedef struct packed {
    logic [VEC_KEY_W-1:0]  qx;
    logic [VEC_KEY_W-1:0]  qy;
    logic [VEC_KEY_W-1:0]  r;
    logic [VEC_KEY_W-1:0]  s;
    logic [VEC_HASH_W-1:0] hash;
    expect_e               expct;
  } ecdsa_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_GRADE,
    ST_DONE
  } state_e;

  // An "acceptable" vector may legitimately go either way, so it always passes.
  function automatic logic grade_f(input expect_e e, input logic ok);
    case (e)
      VALID:   return ok;
      INVALID: return !ok;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ecdsa_vec_timeout_ctr.sv
// Response timer for the vector player.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (has priority over en)
//   en         : count one cycle
//   expired    : count has reached TIMEOUT; the count then holds
module ecdsa_vec_timeout_ctr
  import ecdsa_vec_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/ecdsa_vector_player.sv
// Plays ECDSA verification vectors from a synchronous ROM into a verify
// engine and grades each verdict.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : run pulse, honoured only in IDLE or DONE
//   rom_addr, rom_rd  : ROM index and read strobe (data one cycle later)
//   rom_qx..rom_expect: ROM vector fields
//   req_*             : request channel to the engine (valid/ready)
//   rsp_valid, rsp_ok : engine verdict
//   busy, done        : run status (done sticky until next start)
//   pass/fail/skip_cnt, timeout_flag, first_fail_idx : run statistics
module ecdsa_vector_player
  import ecdsa_vec_pkg::*;
#(
  parameter int KEY_W   = 256,
  parameter int HASH_W  = 512,
  parameter int NUM_VEC = 512,
  parameter int IDX_W   = $clog2(NUM_VEC + 1),
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  rom_addr,
  output logic              rom_rd,
  input  logic [KEY_W-1:0]  rom_qx,
  input  logic [KEY_W-1:0]  rom_qy,
  input  logic [KEY_W-1:0]  rom_r,
  input  logic [KEY_W-1:0]  rom_s,
  input  logic [HASH_W-1:0] rom_hash,
  input  logic [1:0]        rom_expect,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [KEY_W-1:0]  req_qx,
  output logic [KEY_W-1:0]  req_qy,
  output logic [KEY_W-1:0]  req_r,
  output logic [KEY_W-1:0]  req_s,
  output logic [HASH_W-1:0] req_hash,
  input  logic              rsp_valid,
  input  logic              rsp_ok,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  pass_cnt,
  output logic [IDX_W-1:0]  fail_cnt,
  output logic [IDX_W-1:0]  skip_cnt,
  output logic              timeout_flag,
  output logic [IDX_W-1:0]  first_fail_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  expect_e          exp_q;
  logic             ok_q;
  logic             tmo_q;
  logic             tmr_expired;

  assign rom_addr = idx;

  ecdsa_vec_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (req_valid && req_ready),
    .en      (state == ST_WAIT_RSP),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      rom_rd         <= 1'b0;
      req_valid      <= 1'b0;
      req_qx         <= '0;
      req_qy         <= '0;
      req_r          <= '0;
      req_s          <= '0;
      req_hash       <= '0;
      exp_q          <= VALID;
      ok_q           <= 1'b0;
      tmo_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      skip_cnt       <= '0;
      timeout_flag   <= 1'b0;
      first_fail_idx <= '1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            skip_cnt       <= '0;
            timeout_flag   <= 1'b0;
            first_fail_idx <= '1;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            rom_rd         <= 1'b1;
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rom_rd <= 1'b0;
          state  <= ST_LOAD;
        end
        ST_LOAD: begin
          req_qx   <= rom_qx;
          req_qy   <= rom_qy;
          req_r    <= rom_r;
          req_s    <= rom_s;
          req_hash <= rom_hash;
          exp_q    <= expect_e'(rom_expect);
          tmo_q    <= 1'b0;
          if (expect_e'(rom_expect) == SKIP) begin
            skip_cnt <= skip_cnt + IDX_W'(1);
            state    <= ST_GRADE;
          end else begin
            req_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // A response on the expiry cycle still wins over the timeout.
          if (rsp_valid) begin
            ok_q  <= rsp_ok;
            state <= ST_GRADE;
          end else if (tmr_expired) begin
            tmo_q        <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= ST_GRADE;
          end
        end
        ST_GRADE: begin
          if (exp_q != SKIP) begin
            if (!tmo_q && grade_f(exp_q, ok_q)) begin
              pass_cnt <= pass_cnt + IDX_W'(1);
            end else begin
              fail_cnt <= fail_cnt + IDX_W'(1);
              if (first_fail_idx == '1) first_fail_idx <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx    <= idx + IDX_W'(1);
            rom_rd <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_vector_player.sv
// Scoreboard bench for ecdsa_vector_player: a ROM model and an engine model
// drive the DUT; expected requests and run statistics are queued by the
// stimulus and popped by a monitor when the DUT presents them.
module tb_ecdsa_vector_player;

  localparam int KW = 256;
  localparam int HW = 512;
  localparam int NV = 4;
  localparam int TO = 10;
  localparam int IW = $clog2(NV + 1);

  logic          clk, rst_n, start;
  logic [IW-1:0] rom_addr;
  logic          rom_rd;
  logic [KW-1:0] rom_qx, rom_qy, rom_r, rom_s;
  logic [HW-1:0] rom_hash;
  logic [1:0]    rom_expect;
  logic          req_valid, req_ready;
  logic [KW-1:0] req_qx, req_qy, req_r, req_s;
  logic [HW-1:0] req_hash;
  logic          rsp_valid, rsp_ok;
  logic          busy, done, timeout_flag;
  logic [IW-1:0] pass_cnt, fail_cnt, skip_cnt, first_fail_idx;

  ecdsa_vector_player #(
    .KEY_W(KW), .HASH_W(HW), .NUM_VEC(NV), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_qx(rom_qx), .rom_qy(rom_qy), .rom_r(rom_r), .rom_s(rom_s),
    .rom_hash(rom_hash), .rom_expect(rom_expect),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_qx(req_qx), .req_qy(req_qy), .req_r(req_r), .req_s(req_s),
    .req_hash(req_hash),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
    .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .timeout_flag(timeout_flag), .first_fail_idx(first_fail_idx)
  );

  typedef struct {
    logic [KW-1:0] qx, qy, r, s;
    logic [HW-1:0] h;
  } req_t;

  typedef struct {
    int pass, fail, skip, tf, ffi, cyc, hs;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0] exp_tab  [NV];
  logic       ok_tab   [NV];
  int         hold_tab [NV];
  int         lat_tab  [NV];
  int         stray_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [KW-1:0] pat_k(input int base, input int i);
    logic [7:0] b;
    b = 8'(base + i);
    return {32{b}};
  endfunction

  function automatic logic [HW-1:0] pat_h(input int i);
    logic [7:0] b;
    b = 8'(8'h50 + i);
    return {64{b}};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ROM model: address sampled while rom_rd is high, data appears next cycle.
  initial begin
    int a;
    rom_qx = '0; rom_qy = '0; rom_r = '0; rom_s = '0; rom_hash = '0; rom_expect = 2'd0;
    forever begin
      @(negedge clk); #3;
      if (rom_rd) begin
        a = int'(rom_addr);
        if (a >= NV) a = 0;
        @(posedge clk); #1;
        rom_qx     = pat_k(8'h10, a);
        rom_qy     = pat_k(8'h20, a);
        rom_r      = pat_k(8'h30, a);
        rom_s      = pat_k(8'h40, a);
        rom_hash   = pat_h(a);
        rom_expect = exp_tab[a];
      end
    end
  end

  // Engine model: per-vector ready hold-off and response latency (-1 = silent).
  initial begin
    int  v, cur, rwait, wcnt;
    bit  pend;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_ok = 1'b0;
    pend = 0; wcnt = 0; cur = 0; rwait = 0;
    forever begin
      @(negedge clk);
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_ok = 1'b0;
      if (!rst_n) begin
        pend = 0; wcnt = 0;
      end else begin
        if (pend) begin
          if (rwait == 0) begin
            rsp_valid = 1'b1; rsp_ok = ok_tab[cur]; pend = 0;
          end else begin
            rwait--;
          end
        end else if (rom_rd && int'(rom_addr) == stray_idx) begin
          rsp_valid = 1'b1; rsp_ok = !ok_tab[stray_idx];
        end
        if (req_valid) begin
          v = int'(req_qx[7:0]) - 8'h10;
          if (v < 0 || v >= NV) v = 0;
          if (wcnt < hold_tab[v]) begin
            wcnt++;
          end else begin
            req_ready = 1'b1; wcnt = 0; cur = v;
            if (lat_tab[v] >= 0) begin pend = 1; rwait = lat_tab[v]; end
          end
        end
      end
    end
  end

  // Monitor: request payload/stability and end-of-run statistics.
  initial begin
    logic pv, pr, pd;
    req_t snap, e;
    res_t r;
    int   cyc, hs;
    pv = 0; pr = 0; pd = 0; cyc = 0; hs = 0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        pv = 0; pr = 0; pd = 0; cyc = 0; hs = 0;
      end else begin
        if (busy) cyc++;
        if (pv && !pr) chk("req_valid_held", 512'(req_valid), 512'(1));
        if (req_valid && !pv) begin
          snap.qx = req_qx; snap.qy = req_qy; snap.r = req_r; snap.s = req_s; snap.h = req_hash;
        end else if (req_valid) begin
          chk("stable_qx", 512'(req_qx), 512'(snap.qx));
          chk("stable_qy", 512'(req_qy), 512'(snap.qy));
          chk("stable_r", 512'(req_r), 512'(snap.r));
          chk("stable_s", 512'(req_s), 512'(snap.s));
          chk("stable_hash", req_hash, snap.h);
        end
        if (req_valid && req_ready) begin
          hs++;
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected actual=handshake required=none qx=%0h", req_qx);
          end else begin
            e = req_q.pop_front();
            chk("req_qx", 512'(req_qx), 512'(e.qx));
            chk("req_qy", 512'(req_qy), 512'(e.qy));
            chk("req_r", 512'(req_r), 512'(e.r));
            chk("req_s", 512'(req_s), 512'(e.s));
            chk("req_hash", req_hash, e.h);
          end
        end
        if (done && !pd) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected actual=done required=none");
          end else begin
            r = res_q.pop_front();
            chk("pass_cnt", 512'(pass_cnt), 512'(r.pass));
            chk("fail_cnt", 512'(fail_cnt), 512'(r.fail));
            chk("skip_cnt", 512'(skip_cnt), 512'(r.skip));
            chk("timeout_flag", 512'(timeout_flag), 512'(r.tf));
            chk("first_fail_idx", 512'(first_fail_idx), 512'(r.ffi));
            chk("run_cycles", 512'(cyc), 512'(r.cyc));
            chk("requests", 512'(hs), 512'(r.hs));
            chk("busy_at_done", 512'(busy), 512'(0));
          end
          cyc = 0; hs = 0;
        end
        pv = req_valid; pr = req_ready; pd = done;
      end
    end
  end

  task automatic set_exp(input logic [1:0] e0, e1, e2, e3);
    exp_tab[0] = e0; exp_tab[1] = e1; exp_tab[2] = e2; exp_tab[3] = e3;
    for (int i = 0; i < NV; i++) begin
      ok_tab[i]   = (exp_tab[i] == 2'd0) || (exp_tab[i] == 2'd2);
      hold_tab[i] = 0;
      lat_tab[i]  = 0;
    end
    stray_idx = -1;
  endtask

  task automatic push_req(input int i);
    req_t q;
    q.qx = pat_k(8'h10, i); q.qy = pat_k(8'h20, i);
    q.r  = pat_k(8'h30, i); q.s  = pat_k(8'h40, i);
    q.h  = pat_h(i);
    req_q.push_back(q);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    logic [IW-1:0] ones;
    ones = '1;
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_done"}, 512'(done), 512'(0));
    chk({tag, "_req_valid"}, 512'(req_valid), 512'(0));
    chk({tag, "_rom_rd"}, 512'(rom_rd), 512'(0));
    chk({tag, "_rom_addr"}, 512'(rom_addr), 512'(0));
    chk({tag, "_timeout_flag"}, 512'(timeout_flag), 512'(0));
    chk({tag, "_pass_cnt"}, 512'(pass_cnt), 512'(0));
    chk({tag, "_fail_cnt"}, 512'(fail_cnt), 512'(0));
    chk({tag, "_skip_cnt"}, 512'(skip_cnt), 512'(0));
    chk({tag, "_first_fail_idx"}, 512'(first_fail_idx), 512'(ones));
    chk({tag, "_req_qx"}, 512'(req_qx), 512'(0));
    chk({tag, "_req_hash"}, req_hash, 512'(0));
  endtask

  task automatic run(input int ep, ef, es, et, effi, ecyc, ehs, mid);
    res_t r;
    r.pass = ep; r.fail = ef; r.skip = es; r.tf = et; r.ffi = effi; r.cyc = ecyc; r.hs = ehs;
    res_q.push_back(r);
    for (int i = 0; i < NV; i++) if (exp_tab[i] != 2'd3) push_req(i);
    pulse_start();
    chk("busy_after_start", 512'(busy), 512'(1));
    chk("done_after_start", 512'(done), 512'(0));
    for (int c = 0; c < 400; c++) begin
      if (done) break;
      start = (mid > 0 && c == mid);
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait actual=done_low required=done_high");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Baseline: all verdicts correct, one skip.
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    run(3, 0, 1, 0, 7, 18, 3, 0);

    // Vector 2 wrongly accepted, vector 3 wrongly rejected: first failure stays 2.
    set_exp(2'd0, 2'd1, 2'd1, 2'd0);
    ok_tab[2] = 1'b1; ok_tab[3] = 1'b0;
    run(2, 2, 0, 0, 2, 20, 4, 0);

    // Ready held low for 7 cycles on vector 1; a start mid-run is ignored.
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    hold_tab[1] = 7;
    run(3, 0, 1, 0, 7, 25, 3, 8);

    // Silent engine on vector 1: timeout, run continues.
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    lat_tab[1] = -1;
    run(2, 1, 1, 1, 1, 28, 3, 0);

    // Response on the exact expiry cycle counts; stray verdict during FETCH ignored.
    set_exp(2'd0, 2'd1, 2'd1, 2'd3);
    lat_tab[0] = TO;
    stray_idx  = 2;
    run(3, 0, 1, 0, 7, 28, 3, 0);

    // Reset during WAIT_RSP of vector 1, then a clean run.
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    lat_tab[1] = -1;
    push_req(0);
    push_req(1);
    pulse_start();
    repeat (10) @(negedge clk);
    chk("busy_before_abort", 512'(busy), 512'(1));
    #2 rst_n = 1'b0;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_exp(2'd0, 2'd1, 2'd2, 2'd3);
    run(3, 0, 1, 0, 7, 18, 3, 0);

    chk("req_q_drained", 512'(req_q.size()), 512'(0));
    chk("res_q_drained", 512'(res_q.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
